// File: rtl/onchip_logger_pkg.sv
// Shared types and constants for the on-chip sample logger: FSM encoding,
// byte-enable pattern and the RAM size limit used for the region check.
package onchip_logger_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } logger_state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;
    localparam int         RAM_WORDS  = 40000;

endpackage

// File: rtl/onchip_sample_logger_ring_ptr.sv
// Circular-log bookkeeping: next write offset, saturating fill count and the
// sticky wrap flag. A clear request takes precedence over an advance.
module logger_ring_ptr #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 4096,
    parameter int CNT_W       = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              clr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0]  count,
    output logic              wrapped
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH_WORDS);

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              wrapped_reg, wrapped_next;

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        count_next   = count_reg;
        wrapped_next = wrapped_reg;
        if (clr) begin
            wr_ptr_next  = '0;
            count_next   = '0;
            wrapped_next = 1'b0;
        end else if (advance) begin
            if (wr_ptr_reg == LAST_PTR) begin
                wr_ptr_next  = '0;
                wrapped_next = 1'b1;
            end else begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (count_reg != FULL_CNT) begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            wrapped_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            wrapped_reg <= wrapped_next;
        end
    end

    assign wr_ptr  = wr_ptr_reg;
    assign count   = count_reg;
    assign wrapped = wrapped_reg;

endmodule

// File: rtl/onchip_sample_logger.sv
// Avalon-MM master that logs stream samples into a circular RAM region and
// services single-word host readbacks over the same single RAM port.
module onchip_sample_logger
    import onchip_logger_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int BASE_WORD   = 32768,
    parameter int DEPTH_WORDS = 4096,
    parameter int CNT_W       = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_index,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0]  count,
    output logic              wrapped,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata
);

    if (BASE_WORD + DEPTH_WORDS > RAM_WORDS) begin : g_region_check
        $error("onchip_sample_logger: log region runs past the end of the RAM");
    end
    if (DEPTH_WORDS >= (1 << CNT_W)) begin : g_count_check
        $error("onchip_sample_logger: CNT_W too narrow to hold DEPTH_WORDS");
    end

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

    logger_state_t     state_reg, state_next;
    logic              rd_pend_reg, rd_pend_next;
    logic              rd_busy_reg, rd_busy_next;
    logic [ADDR_W-1:0] rd_idx_reg, rd_idx_next;
    logic              clr_pend_reg, clr_pend_next;
    logic [ADDR_W-1:0] m_address_reg, m_address_next;
    logic              m_chipselect_reg, m_chipselect_next;
    logic              m_write_reg, m_write_next;
    logic [3:0]        m_byteenable_reg, m_byteenable_next;
    logic [31:0]       m_writedata_reg, m_writedata_next;
    logic              rd_valid_reg, rd_valid_next;
    logic [31:0]       rd_data_reg, rd_data_next;
    logic              rd_err_reg, rd_err_next;
    logic              ready_int;
    logic              apply_clear;
    logic              ring_adv;
    logic              ring_clr;

    logger_ring_ptr #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .CNT_W       (CNT_W)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (ring_adv),
        .clr     (ring_clr),
        .wr_ptr  (wr_ptr),
        .count   (count),
        .wrapped (wrapped)
    );

    // A clear seen outside IDLE is parked until the FSM comes back to IDLE.
    assign apply_clear = clear | clr_pend_reg;

    always_comb begin
        state_next        = state_reg;
        rd_pend_next      = rd_pend_reg;
        rd_busy_next      = rd_busy_reg;
        rd_idx_next       = rd_idx_reg;
        clr_pend_next     = clr_pend_reg | clear;
        m_address_next    = '0;
        m_chipselect_next = 1'b0;
        m_write_next      = 1'b0;
        m_byteenable_next = 4'h0;
        m_writedata_next  = '0;
        rd_valid_next     = 1'b0;
        rd_data_next      = rd_data_reg;
        rd_err_next       = rd_err_reg;
        ready_int         = 1'b0;
        ring_adv          = 1'b0;
        ring_clr          = 1'b0;

        if (rd_req && !rd_busy_reg) begin
            rd_pend_next = 1'b1;
            rd_busy_next = 1'b1;
            rd_idx_next  = rd_index;
        end

        unique case (state_reg)
            IDLE: begin
                if (apply_clear) begin
                    ring_clr      = 1'b1;
                    clr_pend_next = 1'b0;
                end
                if (rd_pend_reg) begin
                    rd_pend_next = 1'b0;
                    state_next   = RD_ISSUE;
                    // Out-of-range reads never touch the bus.
                    if (rd_idx_reg < DEPTH_LIM) begin
                        m_chipselect_next = 1'b1;
                        m_byteenable_next = BYTEEN_ALL;
                        m_address_next    = BASE_ADDR + rd_idx_reg;
                    end
                end else if (!apply_clear) begin
                    ready_int = 1'b1;
                    if (s_valid) begin
                        m_chipselect_next = 1'b1;
                        m_write_next      = 1'b1;
                        m_byteenable_next = BYTEEN_ALL;
                        m_address_next    = BASE_ADDR + wr_ptr;
                        m_writedata_next  = s_data;
                        state_next        = WRITE;
                    end
                end
            end
            WRITE: begin
                ring_adv   = 1'b1;
                state_next = IDLE;
            end
            RD_ISSUE: begin
                if (rd_idx_reg >= DEPTH_LIM) begin
                    rd_valid_next = 1'b1;
                    rd_err_next   = 1'b1;
                    rd_data_next  = '0;
                    rd_busy_next  = 1'b0;
                    state_next    = IDLE;
                end else begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rd_valid_next = 1'b1;
                rd_err_next   = 1'b0;
                rd_data_next  = m_readdata;
                rd_busy_next  = 1'b0;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            rd_pend_reg      <= 1'b0;
            rd_busy_reg      <= 1'b0;
            rd_idx_reg       <= '0;
            clr_pend_reg     <= 1'b0;
            m_address_reg    <= '0;
            m_chipselect_reg <= 1'b0;
            m_write_reg      <= 1'b0;
            m_byteenable_reg <= 4'h0;
            m_writedata_reg  <= '0;
            rd_valid_reg     <= 1'b0;
            rd_data_reg      <= '0;
            rd_err_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rd_pend_reg      <= rd_pend_next;
            rd_busy_reg      <= rd_busy_next;
            rd_idx_reg       <= rd_idx_next;
            clr_pend_reg     <= clr_pend_next;
            m_address_reg    <= m_address_next;
            m_chipselect_reg <= m_chipselect_next;
            m_write_reg      <= m_write_next;
            m_byteenable_reg <= m_byteenable_next;
            m_writedata_reg  <= m_writedata_next;
            rd_valid_reg     <= rd_valid_next;
            rd_data_reg      <= rd_data_next;
            rd_err_reg       <= rd_err_next;
        end
    end

    assign s_ready      = ready_int & ~reset;
    assign rd_busy      = rd_busy_reg;
    assign rd_valid     = rd_valid_reg;
    assign rd_data      = rd_data_reg;
    assign rd_err       = rd_err_reg;
    assign m_address    = m_address_reg;
    assign m_chipselect = m_chipselect_reg;
    assign m_write      = m_write_reg;
    assign m_byteenable = m_byteenable_reg;
    assign m_writedata  = m_writedata_reg;

endmodule

// File: tb/tb_onchip_sample_logger.sv
// Bench for onchip_sample_logger: directed scenarios then random traffic,
// checked against a transaction-level model of the circular log.
module tb_onchip_sample_logger;

    localparam int AW    = 16;
    localparam int BASE  = 32768;
    localparam int DEPTH = 4;
    localparam int CW    = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, s_valid, s_ready, clear, rd_req, rd_busy, rd_valid, rd_err;
    logic          wrapped, m_chipselect, m_write;
    logic [31:0]   s_data, rd_data, m_writedata, m_readdata;
    logic [AW-1:0] rd_index, wr_ptr, m_address;
    logic [CW-1:0] count;
    logic [3:0]    m_byteenable;

    onchip_sample_logger #(
        .ADDR_W(AW), .BASE_WORD(BASE), .DEPTH_WORDS(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .clear(clear), .rd_req(rd_req), .rd_index(rd_index), .rd_busy(rd_busy),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .wr_ptr(wr_ptr),
        .count(count), .wrapped(wrapped), .m_address(m_address),
        .m_chipselect(m_chipselect), .m_write(m_write), .m_byteenable(m_byteenable),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    // Single-port RAM: registered address, unregistered read data.
    logic [31:0]   ram [0:65535] = '{default: 32'h0};
    logic [AW-1:0] ram_addr_q = '0;
    logic [31:0]   be_mask;
    assign be_mask = {{8{m_byteenable[3]}}, {8{m_byteenable[2]}},
                      {8{m_byteenable[1]}}, {8{m_byteenable[0]}}};
    always @(posedge clk) begin
        if (m_chipselect) begin
            ram_addr_q <= m_address;
            if (m_write) ram[m_address] <= (ram[m_address] & ~be_mask) | (m_writedata & be_mask);
        end
    end
    assign m_readdata = ram[ram_addr_q];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of the log: contents, write offset, fill level, wrap flag.
    logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'h0};
    int          ref_ptr = 0;
    int          ref_count = 0;
    logic        ref_wrapped = 1'b0;

    function automatic void model_write(input logic [31:0] d);
        ref_mem[ref_ptr] = d;
        ref_ptr = (ref_ptr + 1) % DEPTH;
        if (ref_count < DEPTH) ref_count = ref_count + 1;
        if (ref_ptr == 0) ref_wrapped = 1'b1;
    endfunction

    function automatic void model_clear();
        ref_ptr = 0;
        ref_count = 0;
        ref_wrapped = 1'b0;
    endfunction

    typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct { logic [AW-1:0] idx; logic [31:0] data; logic err; int issue_cyc; } rd_exp_t;
    wr_exp_t exp_wr[$];
    rd_exp_t exp_rd[$];
    wr_exp_t mon_we;
    rd_exp_t mon_re;

    bit          outstanding = 1'b0;
    int          cyc = 0;
    int          last_wr_cyc = 0, wr_gap = 0, last_rd_lat = 0, last_rdbus_cyc = 0, cs_cnt = 0;
    logic [31:0] last_rd_data = '0;
    logic        last_rd_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus and readback monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_chipselect) begin
                cs_cnt++;
                if (m_write) begin
                    check_eq("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                    if (exp_wr.size() > 0) begin
                        mon_we = exp_wr.pop_front();
                        check_eq("wr_addr", 32'(m_address), 32'(mon_we.addr));
                        check_eq("wr_data", m_writedata, mon_we.data);
                        check_eq("wr_be", 32'(m_byteenable), 32'hF);
                    end
                    wr_gap = cyc - last_wr_cyc;
                    last_wr_cyc = cyc;
                end else begin
                    check_eq("rd_addr_in_region", 32'((32'(m_address) - BASE) < DEPTH), 32'd1);
                    last_rdbus_cyc = cyc;
                end
            end
            if (rd_valid) begin
                check_eq("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) begin
                    mon_re = exp_rd.pop_front();
                    check_eq("rd_data", rd_data, mon_re.data);
                    check_eq("rd_err", 32'(rd_err), 32'(mon_re.err));
                    last_rd_lat = cyc - mon_re.issue_cyc;
                    $display("readback idx=%0d data=0x%08h err=%0d latency=%0d",
                             mon_re.idx, rd_data, rd_err, last_rd_lat);
                end
                outstanding = 1'b0;
                last_rd_data = rd_data;
                last_rd_err = rd_err;
            end
        end
    end

    // One clock of stimulus; entered on a falling edge, returns on the next one.
    task automatic tick(input bit v, input logic [31:0] d, input bit rq,
                        input logic [AW-1:0] idx, input bit clr, output bit acc);
        s_valid = v; s_data = d; rd_req = rq; rd_index = idx; clear = clr;
        #1;
        check_eq("rd_busy", 32'(rd_busy), 32'(outstanding));
        acc = v && s_ready;
        if (clr) model_clear();
        if (acc) begin
            exp_wr.push_back('{addr: AW'(BASE + ref_ptr), data: d});
            model_write(d);
        end
        if (rq && !outstanding) begin
            outstanding = 1'b1;
            if (int'(idx) < DEPTH)
                exp_rd.push_back('{idx: idx, data: ref_mem[int'(idx)], err: 1'b0, issue_cyc: cyc});
            else
                exp_rd.push_back('{idx: idx, data: 32'h0, err: 1'b1, issue_cyc: cyc});
        end
        @(negedge clk);
    endtask

    task automatic idle_tick();
        bit acc;
        tick(1'b0, 32'h0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic send(input logic [31:0] d);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) tick(1'b1, d, 1'b0, '0, 1'b0, acc);
        check_eq("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic read_req(input logic [AW-1:0] idx);
        bit acc;
        tick(1'b0, 32'h0, 1'b1, idx, 1'b0, acc);
    endtask

    task automatic settle();
        int k = 0;
        while ((outstanding || exp_wr.size() > 0) && k < 60) begin
            idle_tick();
            k++;
        end
        check_eq("settle_done", 32'(outstanding || exp_wr.size() > 0), 32'd0);
        repeat (3) idle_tick();
    endtask

    task automatic check_state();
        check_eq("wr_ptr", 32'(wr_ptr), 32'(ref_ptr));
        check_eq("count", 32'(count), 32'(ref_count));
        check_eq("wrapped", 32'(wrapped), 32'(ref_wrapped));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          cs0;
        int          p;
        logic [AW-1:0] idx;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; clear = 1'b0; rd_req = 1'b0; rd_index = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_cs", 32'(m_chipselect), 32'd0);
        check_eq("rst_write", 32'(m_write), 32'd0);
        check_eq("rst_addr", 32'(m_address), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_busy", 32'(rd_busy), 32'd0);
        check_eq("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_wrapped", 32'(wrapped), 32'd0);
        reset = 1'b0;
        idle_tick();
        #1;
        check_eq("s_ready_after_reset", 32'(s_ready), 32'd1);

        // Three back-to-back samples land on consecutive words, one per two cycles.
        send(32'hA1); send(32'hA2); send(32'hA3);
        settle();
        check_eq("t1_wr_gap", 32'(wr_gap), 32'd2);
        check_eq("t1_wr_ptr", 32'(wr_ptr), 32'd3);
        check_eq("t1_count", 32'(count), 32'd3);
        check_eq("t1_wrapped", 32'(wrapped), 32'd0);

        // Three more: ring wraps, count saturates.
        send(32'hB4); send(32'hB5); send(32'hB6);
        settle();
        check_eq("t2_wr_ptr", 32'(wr_ptr), 32'd2);
        check_eq("t2_count", 32'(count), 32'd4);
        check_eq("t2_wrapped", 32'(wrapped), 32'd1);

        // Clear in IDLE, write offset 0, read it back with minimum latency.
        tick(1'b0, 32'h0, 1'b0, '0, 1'b1, acc);
        send(32'hDEADBEEF);
        settle();
        read_req('0);
        settle();
        check_eq("t3_rd_data", last_rd_data, 32'hDEADBEEF);
        check_eq("t3_rd_err", 32'(last_rd_err), 32'd0);
        check_eq("t3_latency", 32'(last_rd_lat), 32'd4);

        // Out-of-range index: error response without any bus cycle.
        cs0 = cs_cnt;
        read_req(AW'(DEPTH));
        settle();
        check_eq("t4_rd_err", 32'(last_rd_err), 32'd1);
        check_eq("t4_rd_data", last_rd_data, 32'h0);
        check_eq("t4_no_cs", 32'(cs_cnt), 32'(cs0));

        // Read request together with a sample: the write goes first; a
        // second request while busy is dropped.
        idx = AW'(ref_ptr);
        tick(1'b1, 32'hC0FFEE55, 1'b1, idx, 1'b0, acc);
        check_eq("t5_accept", 32'(acc), 32'd1);
        read_req(AW'(2));
        settle();
        check_eq("t5_rd_data", last_rd_data, 32'hC0FFEE55);
        check_eq("t5_order", 32'(last_rdbus_cyc > last_wr_cyc), 32'd1);

        // Clear during WRITE: write completes, pointers zero afterwards.
        p = ref_ptr;
        send(32'h600D0001);
        tick(1'b0, 32'h0, 1'b0, '0, 1'b1, acc);
        settle();
        check_eq("t6_wr_ptr", 32'(wr_ptr), 32'd0);
        check_eq("t6_count", 32'(count), 32'd0);
        check_eq("t6_wrapped", 32'(wrapped), 32'd0);
        read_req(AW'(p));
        settle();
        check_eq("t6_kept_data", last_rd_data, 32'h600D0001);

        // Reset while the read sits in RD_WAIT: the read is abandoned.
        send(32'h77);
        settle();
        read_req('0);
        idle_tick();
        idle_tick();
        reset = 1'b1;
        exp_rd.delete();
        outstanding = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        check_eq("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("t6_rst_cs", 32'(m_chipselect), 32'd0);
        check_eq("t6_rst_busy", 32'(rd_busy), 32'd0);
        check_eq("t6_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check_eq("t6_rst_count", 32'(count), 32'd0);
        check_eq("t6_rst_rd_data", rd_data, 32'h0);
        reset = 1'b0;
        repeat (4) idle_tick();
        check_eq("t6_no_late_rd", 32'(last_rd_data), 32'h600D0001);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
                 AW'($urandom_range(0, DEPTH + 1)), $urandom_range(0, 39) == 0, acc);
        end
        settle();
        check_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
